// File: rtl/fetch_stream_buffer.sv
// Instruction-fetch stream buffer: issues line reads, packs returned beats into a
// circular byte buffer and presents a byte-aligned decode window at the current RIP.
module fetch_stream_buffer #(
    parameter int ADDR_W       = 64,
    parameter int BEAT_BYTES   = 8,
    parameter int LINE_BYTES   = 64,
    parameter int BUF_LINES    = 2,
    parameter int WINDOW_BYTES = 15
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [ADDR_W-1:0]                 entry,
    input  logic                              redirect_valid,
    input  logic [ADDR_W-1:0]                 redirect_addr,
    output logic                              bus_req_valid,
    output logic [ADDR_W-1:0]                 bus_req_addr,
    input  logic                              bus_req_ack,
    input  logic                              bus_resp_valid,
    input  logic [BEAT_BYTES*8-1:0]           bus_resp_data,
    output logic [WINDOW_BYTES*8-1:0]         win_bytes,
    output logic [$clog2(WINDOW_BYTES+1)-1:0] win_count,
    output logic [ADDR_W-1:0]                 win_rip,
    input  logic [$clog2(WINDOW_BYTES+1)-1:0] consume,
    output logic                              consume_err
);

    localparam int CAP    = BUF_LINES * LINE_BYTES;
    localparam int PTR_W  = $clog2(CAP);
    localparam int OCC_W  = PTR_W + 1;
    localparam int BPL    = LINE_BYTES / BEAT_BYTES;
    localparam int BCNT_W = (BPL > 1) ? $clog2(BPL) : 1;
    localparam int OFF_W  = (LINE_BYTES > 1) ? $clog2(LINE_BYTES) : 1;
    localparam int CNT_W  = $clog2(WINDOW_BYTES + 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        BEATS = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [ADDR_W-1:0]         fetch_addr_q, fetch_addr_d;
    logic [OFF_W-1:0]          skip_q, skip_d;
    logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0]          occ_q, occ_d;
    logic [ADDR_W-1:0]         win_rip_q, win_rip_d;
    logic [BCNT_W-1:0]         beat_cnt_q, beat_cnt_d;
    logic                      req_valid_q, req_valid_d;
    logic [ADDR_W-1:0]         req_addr_q, req_addr_d;
    logic [WINDOW_BYTES*8-1:0] win_bytes_q, win_bytes_d;
    logic [CNT_W-1:0]          win_count_q, win_count_d;
    logic                      err_q, err_d;
    logic [7:0]                buf_q [CAP];
    logic [7:0]                buf_d [CAP];

    logic                      beat_write_s;
    logic                      consume_ok_s;
    logic                      last_beat_s;
    logic [OCC_W-1:0]          n_wr_s;

    assign last_beat_s  = (beat_cnt_q == BCNT_W'(BPL - 1));
    assign beat_write_s = bus_resp_valid && (state_q == BEATS) && !redirect_valid;
    assign consume_ok_s = !redirect_valid && (consume <= win_count_q);

    // Beat packing: bytes below the line skip offset are dropped, the rest land contiguously at wr_ptr.
    always_comb begin
        buf_d  = buf_q;
        n_wr_s = {OCC_W{1'b0}};
        if (beat_write_s) begin
            for (int j = 0; j < BEAT_BYTES; j++) begin
                if ((int'(beat_cnt_q) * BEAT_BYTES + j) >= int'(skip_q)) begin
                    buf_d[wr_ptr_q + n_wr_s[PTR_W-1:0]] = bus_resp_data[8*j +: 8];
                    n_wr_s = n_wr_s + OCC_W'(1);
                end else begin
                    n_wr_s = n_wr_s;
                end
            end
        end else begin
            n_wr_s = {OCC_W{1'b0}};
        end
    end

    // Fetch FSM, pointer bookkeeping and registered window construction.
    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        skip_d       = skip_q;
        beat_cnt_d   = beat_cnt_q;
        req_valid_d  = req_valid_q;
        req_addr_d   = req_addr_q;
        err_d        = err_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q + n_wr_s[PTR_W-1:0];
        win_rip_d    = win_rip_q;
        occ_d        = occ_q + n_wr_s;

        case (state_q)
            IDLE: begin
                if (redirect_valid) begin
                    state_d     = REQ;
                    req_valid_d = 1'b1;
                    req_addr_d  = redirect_addr & ~LINE_MASK;
                end else if ((OCC_W'(CAP) - occ_q) >= OCC_W'(LINE_BYTES)) begin
                    state_d     = REQ;
                    req_valid_d = 1'b1;
                    req_addr_d  = fetch_addr_q;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (bus_req_ack) begin
                    state_d     = redirect_valid ? DRAIN : BEATS;
                    req_valid_d = 1'b0;
                    beat_cnt_d  = {BCNT_W{1'b0}};
                end else if (redirect_valid) begin
                    state_d     = IDLE;
                    req_valid_d = 1'b0;
                end else begin
                    state_d = REQ;
                end
            end
            BEATS: begin
                if (bus_resp_valid) begin
                    beat_cnt_d = beat_cnt_q + BCNT_W'(1);
                    if (last_beat_s) begin
                        state_d      = IDLE;
                        fetch_addr_d = fetch_addr_q + ADDR_W'(LINE_BYTES);
                        skip_d       = {OFF_W{1'b0}};
                    end else begin
                        state_d = redirect_valid ? DRAIN : BEATS;
                    end
                end else begin
                    state_d = redirect_valid ? DRAIN : BEATS;
                end
            end
            DRAIN: begin
                if (bus_resp_valid) begin
                    beat_cnt_d = beat_cnt_q + BCNT_W'(1);
                    state_d    = last_beat_s ? IDLE : DRAIN;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d     = IDLE;
                req_valid_d = 1'b0;
            end
        endcase

        if (redirect_valid) begin
            rd_ptr_d     = {PTR_W{1'b0}};
            wr_ptr_d     = {PTR_W{1'b0}};
            occ_d        = {OCC_W{1'b0}};
            win_rip_d    = redirect_addr;
            fetch_addr_d = redirect_addr & ~LINE_MASK;
            skip_d       = redirect_addr[OFF_W-1:0];
        end else if (consume_ok_s) begin
            rd_ptr_d  = rd_ptr_q + PTR_W'(consume);
            occ_d     = occ_q + n_wr_s - OCC_W'(consume);
            win_rip_d = win_rip_q + ADDR_W'(consume);
        end else begin
            err_d = 1'b1;
        end

        if (occ_d > OCC_W'(WINDOW_BYTES)) begin
            win_count_d = CNT_W'(WINDOW_BYTES);
        end else begin
            win_count_d = occ_d[CNT_W-1:0];
        end

        win_bytes_d = {(WINDOW_BYTES*8){1'b0}};
        for (int i = 0; i < WINDOW_BYTES; i++) begin
            if (OCC_W'(i) < occ_d) begin
                win_bytes_d[8*i +: 8] = buf_d[rd_ptr_d + PTR_W'(i)];
            end else begin
                win_bytes_d[8*i +: 8] = 8'h00;
            end
        end
    end

    // Control and window registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            fetch_addr_q <= entry & ~LINE_MASK;
            skip_q       <= entry[OFF_W-1:0];
            rd_ptr_q     <= {PTR_W{1'b0}};
            wr_ptr_q     <= {PTR_W{1'b0}};
            occ_q        <= {OCC_W{1'b0}};
            win_rip_q    <= entry;
            beat_cnt_q   <= {BCNT_W{1'b0}};
            req_valid_q  <= 1'b0;
            req_addr_q   <= {ADDR_W{1'b0}};
            win_bytes_q  <= {(WINDOW_BYTES*8){1'b0}};
            win_count_q  <= {CNT_W{1'b0}};
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            skip_q       <= skip_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            occ_q        <= occ_d;
            win_rip_q    <= win_rip_d;
            beat_cnt_q   <= beat_cnt_d;
            req_valid_q  <= req_valid_d;
            req_addr_q   <= req_addr_d;
            win_bytes_q  <= win_bytes_d;
            win_count_q  <= win_count_d;
            err_q        <= err_d;
        end
    end

    // Byte storage; contents are only meaningful where occupancy covers them, so no reset.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign bus_req_valid = req_valid_q;
    assign bus_req_addr  = req_addr_q;
    assign win_bytes     = win_bytes_q;
    assign win_count     = win_count_q;
    assign win_rip       = win_rip_q;
    assign consume_err   = err_q;

endmodule

// File: tb/tb_fetch_stream_buffer.sv
// Directed self-checking bench for fetch_stream_buffer with default parameters.
module tb_fetch_stream_buffer;

    logic         clk;
    logic         reset;
    logic [63:0]  entry;
    logic         redirect_valid;
    logic [63:0]  redirect_addr;
    logic         bus_req_valid;
    logic [63:0]  bus_req_addr;
    logic         bus_req_ack;
    logic         bus_resp_valid;
    logic [63:0]  bus_resp_data;
    logic [119:0] win_bytes;
    logic [3:0]   win_count;
    logic [63:0]  win_rip;
    logic [3:0]   consume;
    logic         consume_err;

    int n_checks;
    int n_errors;

    fetch_stream_buffer dut (
        .clk            (clk),
        .reset          (reset),
        .entry          (entry),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .bus_req_valid  (bus_req_valid),
        .bus_req_addr   (bus_req_addr),
        .bus_req_ack    (bus_req_ack),
        .bus_resp_valid (bus_resp_valid),
        .bus_resp_data  (bus_resp_data),
        .win_bytes      (win_bytes),
        .win_count      (win_count),
        .win_rip        (win_rip),
        .consume        (consume),
        .consume_err    (consume_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: each byte is a fixed function of its address.
    function automatic logic [7:0] mem_byte(input logic [63:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    function automatic logic [63:0] beat_data(input logic [63:0] a);
        logic [63:0] d;
        for (int j = 0; j < 8; j++) d[8*j +: 8] = mem_byte(a + 64'(j));
        return d;
    endfunction

    function automatic logic [119:0] win_model(input logic [63:0] rip, input int cnt);
        logic [119:0] w;
        w = 120'd0;
        for (int i = 0; i < 15; i++) begin
            if (i < cnt) w[8*i +: 8] = mem_byte(rip + 64'(i));
        end
        return w;
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits for a request, checks its address, acks it and returns eight beats of that line.
    task automatic run_line(input logic [63:0] exp_addr, input int redir_beat, input logic [63:0] redir_to);
        int n;
        n = 0;
        while (!bus_req_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("req_valid", 128'(bus_req_valid), 128'(1'b1));
        check_eq("req_addr", 128'(bus_req_addr), 128'(exp_addr));
        bus_req_ack = 1'b1;
        @(negedge clk);
        bus_req_ack = 1'b0;
        check_eq("req_drop", 128'(bus_req_valid), 128'(1'b0));
        for (int b = 0; b < 8; b++) begin
            bus_resp_valid = 1'b1;
            bus_resp_data  = beat_data(exp_addr + 64'(b * 8));
            if (b == redir_beat) begin
                redirect_valid = 1'b1;
                redirect_addr  = redir_to;
            end
            @(negedge clk);
            bus_resp_valid = 1'b0;
            redirect_valid = 1'b0;
        end
    endtask

    task automatic consume_n(input int times, input logic [3:0] amt);
        for (int k = 0; k < times; k++) begin
            consume = amt;
            @(negedge clk);
        end
        consume = 4'd0;
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        reset          = 1'b0;
        entry          = 64'h1003;
        redirect_valid = 1'b0;
        redirect_addr  = 64'd0;
        bus_req_ack    = 1'b0;
        bus_resp_valid = 1'b0;
        bus_resp_data  = 64'd0;
        consume        = 4'd0;
        @(negedge clk);
        @(negedge clk);

        check_eq("rst_req_valid", 128'(bus_req_valid), 128'(1'b0));
        check_eq("rst_win_count", 128'(win_count), 128'(4'd0));
        check_eq("rst_win_bytes", 128'(win_bytes), 128'(120'd0));
        check_eq("rst_win_rip", 128'(win_rip), 128'(64'h1003));
        check_eq("rst_err", 128'(consume_err), 128'(1'b0));

        reset = 1'b1;
        @(negedge clk);
        check_eq("first_req_latency", 128'(bus_req_valid), 128'(1'b1));
        @(negedge clk);
        @(negedge clk);
        check_eq("req_hold_valid", 128'(bus_req_valid), 128'(1'b1));
        check_eq("req_hold_addr", 128'(bus_req_addr), 128'(64'h1000));

        // First line with skip 3: 61 bytes stored.
        run_line(64'h1000, 8, 64'd0);
        check_eq("l1_count", 128'(win_count), 128'(4'd15));
        check_eq("l1_rip", 128'(win_rip), 128'(64'h1003));
        check_eq("l1_byte0", 128'(win_bytes[7:0]), 128'(mem_byte(64'h1003)));
        check_eq("l1_window", 128'(win_bytes), 128'(win_model(64'h1003, 15)));

        // Second line fits (61 <= 64); afterwards 125 bytes leave no room for a third.
        run_line(64'h1040, 8, 64'd0);
        repeat (4) @(negedge clk);
        check_eq("full_no_req", 128'(bus_req_valid), 128'(1'b0));
        check_eq("full_rip", 128'(win_rip), 128'(64'h1003));

        // Consume 75 bytes: occupancy 50, then line 0x1080 wraps the write pointer.
        consume_n(5, 4'd15);
        check_eq("c75_rip", 128'(win_rip), 128'(64'h104E));
        check_eq("c75_byte0", 128'(win_bytes[7:0]), 128'(mem_byte(64'h104E)));
        run_line(64'h1080, 8, 64'd0);
        consume_n(3, 4'd15);
        check_eq("wrap_rip", 128'(win_rip), 128'(64'h107B));
        check_eq("wrap_count", 128'(win_count), 128'(4'd15));
        check_eq("wrap_window", 128'(win_bytes), 128'(win_model(64'h107B, 15)));

        // Redirect during beat 3 of line 0x10C0: remaining beats drained.
        consume_n(1, 4'd15);
        run_line(64'h10C0, 3, 64'h2005);
        check_eq("drain_count", 128'(win_count), 128'(4'd0));
        check_eq("drain_rip", 128'(win_rip), 128'(64'h2005));
        check_eq("drain_idle", 128'(bus_req_valid), 128'(1'b0));
        run_line(64'h2000, 8, 64'd0);
        check_eq("redir_byte0", 128'(win_bytes[7:0]), 128'(mem_byte(64'h2005)));
        check_eq("redir_count", 128'(win_count), 128'(4'd15));

        // Redirect with consume in the same cycle, from IDLE.
        redirect_valid = 1'b1;
        redirect_addr  = 64'h3009;
        consume        = 4'd4;
        @(negedge clk);
        redirect_valid = 1'b0;
        consume        = 4'd0;
        check_eq("rc_rip", 128'(win_rip), 128'(64'h3009));
        check_eq("rc_count", 128'(win_count), 128'(4'd0));
        check_eq("rc_err", 128'(consume_err), 128'(1'b0));
        check_eq("rc_req_valid", 128'(bus_req_valid), 128'(1'b1));
        check_eq("rc_req_addr", 128'(bus_req_addr), 128'(64'h3000));

        // Redirect before ack withdraws the request.
        redirect_valid = 1'b1;
        redirect_addr  = 64'h4010;
        @(negedge clk);
        redirect_valid = 1'b0;
        check_eq("withdraw", 128'(bus_req_valid), 128'(1'b0));
        run_line(64'h4000, 8, 64'd0);
        check_eq("l4_count", 128'(win_count), 128'(4'd15));
        check_eq("l4_byte0", 128'(win_bytes[7:0]), 128'(mem_byte(64'h4010)));

        // Over-consume: 48 - 45 = 3 bytes left, then ask for 5.
        consume_n(3, 4'd15);
        check_eq("oc_count3", 128'(win_count), 128'(4'd3));
        consume_n(1, 4'd5);
        check_eq("oc_err", 128'(consume_err), 128'(1'b1));
        check_eq("oc_rip", 128'(win_rip), 128'(64'h403D));
        check_eq("oc_count", 128'(win_count), 128'(4'd3));
        repeat (3) @(negedge clk);
        check_eq("oc_err_sticky", 128'(consume_err), 128'(1'b1));
        consume_n(1, 4'd3);
        check_eq("oc_after_rip", 128'(win_rip), 128'(64'h4040));
        check_eq("oc_after_count", 128'(win_count), 128'(4'd0));
        check_eq("oc_err_held", 128'(consume_err), 128'(1'b1));

        // Reset in the middle of line 0x4040, then stray beats.
        check_eq("l5_req_addr", 128'(bus_req_addr), 128'(64'h4040));
        bus_req_ack = 1'b1;
        @(negedge clk);
        bus_req_ack = 1'b0;
        for (int b = 0; b < 3; b++) begin
            bus_resp_valid = 1'b1;
            bus_resp_data  = beat_data(64'h4040 + 64'(b * 8));
            @(negedge clk);
        end
        bus_resp_valid = 1'b0;
        reset = 1'b0;
        entry = 64'h5000;
        @(negedge clk);
        check_eq("mr_req_valid", 128'(bus_req_valid), 128'(1'b0));
        check_eq("mr_count", 128'(win_count), 128'(4'd0));
        check_eq("mr_bytes", 128'(win_bytes), 128'(120'd0));
        check_eq("mr_rip", 128'(win_rip), 128'(64'h5000));
        check_eq("mr_err", 128'(consume_err), 128'(1'b0));
        reset = 1'b1;
        for (int b = 3; b < 8; b++) begin
            bus_resp_valid = 1'b1;
            bus_resp_data  = beat_data(64'h4040 + 64'(b * 8));
            @(negedge clk);
        end
        bus_resp_valid = 1'b0;
        check_eq("stray_count", 128'(win_count), 128'(4'd0));
        check_eq("stray_req_valid", 128'(bus_req_valid), 128'(1'b1));
        run_line(64'h5000, 8, 64'd0);
        check_eq("l6_window", 128'(win_bytes), 128'(win_model(64'h5000, 15)));
        check_eq("l6_rip", 128'(win_rip), 128'(64'h5000));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
